// File: rtl/psram_skew_gen.sv
// PSRAM DQ/RWDS stimulus generator: FIFO-fed bursts under CSN with a programmable per-lane delay.
// Optional X-on-transition modelling is enabled by defining PSRAM_SKEW_GEN_XTRANS_EN.
module psram_skew_gen #(
    parameter int unsigned DQ_W   = 16,
    parameter int unsigned RWDS_W = 2,
    parameter int unsigned DLY_W  = 3,
    parameter int unsigned UI_CYC = 4,
    parameter int unsigned FIFO_D = 4,
    parameter int unsigned TCSS   = 2,
    parameter int unsigned TCSH   = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DQ_W-1:0]                    in_data,
    input  logic [RWDS_W-1:0]                  in_rwds,
    input  logic                               in_last,
    input  logic [(DQ_W+RWDS_W)*DLY_W-1:0]     cfg_dly,
    input  logic                               cfg_load,
    output logic                               out_csn,
    output logic [DQ_W-1:0]                    out_dq,
    output logic [RWDS_W-1:0]                  out_rwds,
    output logic                               busy,
    output logic                               err_underrun
);

    localparam int unsigned L     = DQ_W + RWDS_W;
    localparam int unsigned NTAP  = 1 << DLY_W;
    localparam int unsigned PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned ENT_W = L + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {StIdle, StPre, StData, StDrain, StHold} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [L-1:0]       pre_q, pre_d;
    logic               last_seen_q, last_seen_d;
    logic               err_q, err_d;
    logic [L*DLY_W-1:0] dly_q, dly_d;

    // ---------------------------------------------------------------- input FIFO
    logic [ENT_W-1:0] fifo_mem [FIFO_D];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push, pop, fifo_empty;
    logic [ENT_W-1:0] head_ent;
    logic [L-1:0]     head_word;
    logic             head_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Registered count drives in_ready, so a same-cycle pop frees the slot one cycle later.
    assign in_ready   = (count_q != (PTR_W+1)'(FIFO_D));
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid & in_ready;
    assign head_ent   = fifo_mem[rd_ptr_q];
    assign head_word  = head_ent[L-1:0];
    assign head_last  = head_ent[L];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_last, in_rwds, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // ---------------------------------------------------------------- burst FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        last_seen_d = last_seen_q;
        err_d       = err_q;
        dly_d       = dly_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_load) dly_d = cfg_dly;
                if (!fifo_empty) begin
                    state_d = StPre;
                    cnt_d   = '0;
                end
            end
            StPre: begin
                if (cnt_q == CNT_W'(TCSS - 1)) begin
                    state_d     = StData;
                    cnt_d       = '0;
                    pop         = 1'b1;
                    pre_d       = head_word;
                    last_seen_d = head_last;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CNT_W'(UI_CYC - 1)) begin
                    cnt_d = '0;
                    if (last_seen_q) begin
                        state_d     = StDrain;
                        pre_d       = '0;
                        last_seen_d = 1'b0;
                    end else if (fifo_empty) begin
                        // Underrun: keep the previous word for another UI.
                        err_d = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        pre_d       = head_word;
                        last_seen_d = head_last;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (cnt_q == CNT_W'(NTAP - 1)) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == CNT_W'(TCSH - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pre_q       <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
            dly_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
            dly_q       <= dly_d;
        end
    end

    // ---------------------------------------------------------------- delay lines
    // hist_q[i] holds the pre-delay word from i+1 cycles ago; tap[d] is the word d cycles ago.
    logic [L-1:0] hist_q [NTAP-1];
    logic [L-1:0] tap    [NTAP];
    logic [L-1:0] clean;
    logic [L-1:0] out_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP - 1; i++) hist_q[i] <= '0;
        end else begin
            hist_q[0] <= pre_q;
            for (int i = 1; i < NTAP - 1; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    always_comb begin
        tap[0] = pre_q;
        for (int i = 1; i < NTAP; i++) tap[i] = hist_q[i-1];
    end

    always_comb begin
        clean = '0;
        for (int k = 0; k < L; k++) begin
            clean[k] = tap[dly_q[k*DLY_W +: DLY_W]][k];
        end
    end

`ifdef PSRAM_SKEW_GEN_XTRANS_EN
    logic [L-1:0] prev_q;
    logic         xt_active;

    assign xt_active = (state_q == StPre) || (state_q == StData) || (state_q == StDrain);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= clean;
    end

    always_comb begin
        out_word = clean;
        for (int k = 0; k < L; k++) begin
            if (xt_active && (clean[k] != prev_q[k])) out_word[k] = 1'bx;
        end
    end
`else
    assign out_word = clean;
`endif

    assign out_dq       = out_word[DQ_W-1:0];
    assign out_rwds     = out_word[L-1:DQ_W];
    assign out_csn      = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign err_underrun = err_q;

endmodule

// File: tb/tb_psram_skew_gen.sv
// Self-checking bench for psram_skew_gen: directed and randomized bursts against a timeline model.
module tb_psram_skew_gen;

    localparam int DQ_W = 16, RWDS_W = 2, L = 18, DLY_W = 3;
    localparam int UI_CYC = 4, TCSS = 2, TCSH = 2, NTAP = 8;
    localparam int MAXW = 256;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DQ_W-1:0]      in_data = '0;
    logic [RWDS_W-1:0]    in_rwds = '0;
    logic                 in_last = 1'b0;
    logic [L*DLY_W-1:0]   cfg_dly = '0;
    logic                 cfg_load = 1'b0;
    logic                 out_csn;
    logic [DQ_W-1:0]      out_dq;
    logic [RWDS_W-1:0]    out_rwds;
    logic                 busy;
    logic                 err_underrun;

    psram_skew_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_rwds      (in_rwds),
        .in_last      (in_last),
        .cfg_dly      (cfg_dly),
        .cfg_load     (cfg_load),
        .out_csn      (out_csn),
        .out_dq       (out_dq),
        .out_rwds     (out_rwds),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    int           dly [L];
    logic         err_model = 1'b0;
    int           nw;
    logic [L-1:0] bw [4];
    int           bp [4];
    logic [L-1:0] pre_m [MAXW];
    int           csn_rise;
    int           win;
    // Measurements of the last burst
    int           first_one [L];
    int           ones_cnt [L];
    int           csn_low_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [L*DLY_W-1:0] pack_dly();
        logic [L*DLY_W-1:0] v;
        v = '0;
        for (int k = 0; k < L; k++) v[k*DLY_W +: DLY_W] = DLY_W'(dly[k]);
        return v;
    endfunction

    task automatic load_cfg();
        @(posedge clk); #1;
        cfg_dly  = pack_dly();
        cfg_load = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
    endtask

    // Pre-delay timeline: UI starts every UI_CYC cycles from 2+TCSS; a word pushed in cycle p
    // can be taken at UI start s when p <= s-2, otherwise the held word repeats (underrun).
    task automatic build_model();
        int s, i;
        logic [L-1:0] cur;
        for (int t = 0; t < MAXW; t++) pre_m[t] = '0;
        s = 2 + TCSS;
        i = 0;
        cur = '0;
        while (i < nw || s == 2 + TCSS) begin
            if (i < nw && bp[i] <= s - 2) begin
                cur = bw[i];
                i++;
            end else begin
                err_model = 1'b1;
            end
            for (int u = 0; u < UI_CYC; u++) pre_m[s+u] = cur;
            s += UI_CYC;
        end
        csn_rise = s + NTAP + TCSH;
        win = csn_rise + 3;
    endtask

    function automatic logic [31:0] expected_at(input int t);
        logic [L-1:0] lanes;
        logic csn;
        lanes = '0;
        for (int k = 0; k < L; k++) begin
            if (t - dly[k] >= 0) lanes[k] = pre_m[t - dly[k]][k];
        end
        csn = !(t >= 2 && t < csn_rise);
        return {12'h0, csn, !csn, lanes};
    endfunction

    task automatic run_burst(input string tag, input int ld_at, input logic [L*DLY_W-1:0] ld_val);
        logic [31:0] obs;
        build_model();
        csn_low_cnt = 0;
        for (int k = 0; k < L; k++) begin
            first_one[k] = -1;
            ones_cnt[k] = 0;
        end
        for (int r = 0; r < win; r++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            cfg_load = 1'b0;
            for (int i = 0; i < nw; i++) begin
                if (bp[i] == r) begin
                    in_valid = 1'b1;
                    in_data  = bw[i][DQ_W-1:0];
                    in_rwds  = bw[i][L-1:DQ_W];
                    in_last  = (i == nw - 1);
                end
            end
            if (r == ld_at) begin
                cfg_dly  = ld_val;
                cfg_load = 1'b1;
            end
            @(negedge clk);
            obs = {12'h0, out_csn, busy, out_rwds, out_dq};
            check(tag, obs, expected_at(r));
            if (!out_csn) csn_low_cnt++;
            for (int k = 0; k < L; k++) begin
                if (obs[k] === 1'b1) begin
                    ones_cnt[k]++;
                    if (first_one[k] < 0) first_one[k] = r;
                end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        cfg_load = 1'b0;
        @(negedge clk);
        check({tag, "_err"}, {31'h0, err_underrun}, {31'h0, err_model});
        check({tag, "_rdy"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        for (int k = 0; k < L; k++) dly[k] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_vals", {26'h0, out_csn, busy, err_underrun, in_ready, 2'b0},
              {26'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b0});
        check("reset_lanes", {14'h0, out_rwds, out_dq}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero delays, words 1..4 back-to-back
        nw = 4;
        for (int i = 0; i < 4; i++) begin
            bw[i] = L'(i + 1);
            bp[i] = i;
        end
        run_burst("zero_dly", -1, '0);
        check("csn_low_28", csn_low_cnt, 28);

        // Lane 3 delayed by 5
        dly[3] = 5;
        load_cfg();
        nw = 2;
        bw[0] = 18'h0FFFF; bp[0] = 0;
        bw[1] = 18'h00000; bp[1] = 1;
        run_burst("dq3_skew", -1, '0);
        check("dq3_vs_dq0", first_one[3] - first_one[0], 5);

        // RWDS1 delayed 7, others 2: RWDS1 trails by 5 and the last word fully lands
        for (int k = 0; k < L; k++) dly[k] = 2;
        dly[17] = 7;
        load_cfg();
        nw = 2;
        bw[0] = 18'h3FFFF; bp[0] = 0;
        bw[1] = 18'h3FFFF; bp[1] = 1;
        run_burst("rwds1_skew", -1, '0);
        check("rwds1_vs_dq0", first_one[17] - first_one[0], 5);
        check("rwds1_full", ones_cnt[17], 2 * UI_CYC);

        // Underrun: second (last) word 11 cycles after the first
        for (int k = 0; k < L; k++) dly[k] = 0;
        load_cfg();
        nw = 2;
        bw[0] = 18'h00001; bp[0] = 0;
        bw[1] = 18'h00000; bp[1] = 11;
        run_burst("underrun", -1, '0);
        check("held_3ui", ones_cnt[0], 3 * UI_CYC);
        check("err_set", {31'h0, err_underrun}, 32'h1);

        // cfg_load while busy is ignored; the same load in IDLE applies to the next burst
        nw = 3;
        for (int i = 0; i < 3; i++) begin
            bw[i] = L'($urandom);
            bp[i] = i;
        end
        run_burst("ld_busy", 8, {(L*DLY_W){1'b1}});
        for (int k = 0; k < L; k++) dly[k] = 7;
        load_cfg();
        for (int i = 0; i < 3; i++) bw[i] = L'($urandom);
        run_burst("ld_idle", -1, '0);
        check("err_sticky", {31'h0, err_underrun}, 32'h1);

        // Randomized bursts
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < L; k++) dly[k] = int'($urandom_range(0, 7));
            load_cfg();
            nw = int'($urandom_range(1, 4));
            for (int i = 0; i < nw; i++) begin
                bw[i] = L'($urandom);
                bp[i] = (i == 0) ? 0 : bp[i-1] + 1 + int'($urandom_range(0, 6));
            end
            run_burst("rand", -1, '0);
        end

        // Reset three cycles into DATA
        nw = 4;
        for (int i = 0; i < 4; i++) begin
            bw[i] = L'($urandom) | 18'h1;
            bp[i] = i;
        end
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            in_valid = (r < 4);
            in_last  = (r == 3);
            if (r < 4) begin
                in_data = bw[r][DQ_W-1:0];
                in_rwds = bw[r][L-1:DQ_W];
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        #2;
        check("pre_rst_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {26'h0, out_csn, busy, err_underrun, in_ready, 2'b0},
              {26'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b0});
        check("rst_lanes", {14'h0, out_rwds, out_dq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < L; k++) dly[k] = 0;
        err_model = 1'b0;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            check("flushed", {30'h0, out_csn, busy}, 32'h2);
        end

        // Clean burst after reset
        nw = 2;
        bw[0] = L'($urandom); bp[0] = 0;
        bw[1] = L'($urandom); bp[1] = 2;
        run_burst("post_rst", -1, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
